// File: rtl/toggle_event_receiver_if.sv
// Event delivery bus of toggle_event_receiver.
//   master (receiver side): drives ev_valid, ev_seq, pend_cnt, overflow; samples ev_ready, ovf_clr
//   slave  (consumer side): the mirror image
interface toggle_event_receiver_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned SEQ_W = 8
) ();
  logic             ev_valid;
  logic             ev_ready;
  logic [SEQ_W-1:0] ev_seq;
  logic [CNT_W-1:0] pend_cnt;
  logic             overflow;
  logic             ovf_clr;

  modport master (
    output ev_valid, ev_seq, pend_cnt, overflow,
    input  ev_ready, ovf_clr
  );

  modport slave (
    input  ev_valid, ev_seq, pend_cnt, overflow,
    output ev_ready, ovf_clr
  );
endinterface

// File: rtl/toggle_event_receiver.sv
// Receive end of a toggle-encoded event link. Every transition of tog_in is one
// event; events are synchronised, queued in a pending counter and delivered one
// at a time over a valid/ready handshake, each tagged with a wrapping sequence.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   tog_in    toggle line from the remote T flip-flop (asynchronous)
//   ev_total  32-bit count of detected events (only when TOG_RX_STATS_EN is defined)
//   ev        event bus (master): ev_valid/ev_ready/ev_seq, pend_cnt, overflow, ovf_clr
// Optional feature macro: TOG_RX_STATS_EN
module toggle_event_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SEQ_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tog_in,
`ifdef TOG_RX_STATS_EN
  output logic [31:0]            ev_total,
`endif
  toggle_event_receiver_if.master ev
);

  localparam int unsigned INIT_W = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
  logic                   ref_q, ref_d;
  logic                   edge_q, edge_d;
  logic [CNT_W-1:0]       pend_cnt_q, pend_cnt_d;
  logic [SEQ_W-1:0]       ev_seq_q, ev_seq_d;
  logic                   overflow_q, overflow_d;
  logic                   ev_valid_q, ev_valid_d;
  logic                   xfer;
  logic                   drop;
  logic                   sync_out;
`ifdef TOG_RX_STATS_EN
  logic [31:0]            ev_total_q, ev_total_d;
`endif

  assign sync_out = sync_q[SYNC_STAGES-1];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sync_q     <= '0;
      init_cnt_q <= '0;
      ref_q      <= 1'b0;
      edge_q     <= 1'b0;
      pend_cnt_q <= '0;
      ev_seq_q   <= '0;
      overflow_q <= 1'b0;
      ev_valid_q <= 1'b0;
`ifdef TOG_RX_STATS_EN
      ev_total_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      init_cnt_q <= init_cnt_d;
      ref_q      <= ref_d;
      edge_q     <= edge_d;
      pend_cnt_q <= pend_cnt_d;
      ev_seq_q   <= ev_seq_d;
      overflow_q <= overflow_d;
      ev_valid_q <= ev_valid_d;
`ifdef TOG_RX_STATS_EN
      ev_total_q <= ev_total_d;
`endif
    end
  end

  // Next-state, edge detection, pending counter and handshake
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], tog_in};
    init_cnt_d = init_cnt_q;
    ref_d      = ref_q;
    edge_d     = 1'b0;
    pend_cnt_d = pend_cnt_q;
    ev_seq_d   = ev_seq_q;
    overflow_d = overflow_q;
    drop       = 1'b0;
    xfer       = ev_valid_q && ev.ev_ready;

    unique case (state_q)
      // Wait until the synchroniser holds a post-reset sample, then adopt it as
      // the reference so the level present at reset is never counted.
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(SYNC_STAGES)) begin
          ref_d   = sync_out;
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_RUN: begin
        edge_d = sync_out ^ ref_q;
        ref_d  = sync_out;
      end
      default: state_d = ST_INIT;
    endcase

    // edge_q and xfer are both 0 in INIT, so this is naturally idle there.
    unique case ({edge_q, xfer})
      2'b10: begin
        if (pend_cnt_q == {CNT_W{1'b1}}) drop = 1'b1;
        else                              pend_cnt_d = pend_cnt_q + CNT_W'(1);
      end
      2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
      default: pend_cnt_d = pend_cnt_q;
    endcase

    if (xfer) ev_seq_d = ev_seq_q + SEQ_W'(1);

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)            overflow_d = 1'b1;
    else if (ev.ovf_clr) overflow_d = 1'b0;

    ev_valid_d = (state_d == ST_RUN) && (pend_cnt_d != '0);
  end

`ifdef TOG_RX_STATS_EN
  // Counts every detected edge, dropped or not
  always_comb begin
    ev_total_d = ev_total_q + 32'(edge_q);
  end
  assign ev_total = ev_total_q;
`endif

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_seq   = ev_seq_q;
  assign ev.pend_cnt = pend_cnt_q;
  assign ev.overflow = overflow_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Bench for toggle_event_receiver: directed scenarios plus random traffic,
// checked every cycle against an event-level reference model.
module tb_toggle_event_receiver;

  localparam int unsigned S     = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEQ_W = 8;
  localparam int          PMAX  = (1 << CNT_W) - 1;
  localparam int          SMOD  = 1 << SEQ_W;

  logic clk = 1'b0;
  logic rst;
  logic tog_in;
`ifdef TOG_RX_STATS_EN
  logic [31:0] ev_total;
`endif

  toggle_event_receiver_if #(.CNT_W(CNT_W), .SEQ_W(SEQ_W)) ev_if ();

  toggle_event_receiver #(.SYNC_STAGES(S), .CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
`ifdef TOG_RX_STATS_EN
    .ev_total (ev_total),
`endif
    .ev       (ev_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else             n_pass++;
  endtask

  // Reference model: an event is recognised S+1 edges after the edge that
  // sampled a tog_in level different from the previous sample; the first
  // sample after reset is only a reference.
  int  m_pend = 0, m_seq = 0, m_ovf = 0, m_n = 0;
  longint m_total = 0;
  bit  model_ok = 0;
  bit  samp[$];

  always @(posedge clk) begin
    bit r, t, rdy, clr, ev, xfer, drop;
    r = rst; t = tog_in; rdy = ev_if.ev_ready; clr = ev_if.ovf_clr;
    if (r) begin
      m_pend = 0; m_seq = 0; m_ovf = 0; m_total = 0; m_n = 0;
      samp.delete();
      model_ok = 1;
    end else begin
      m_n++;
      samp.push_back(t);
      if (samp.size() > S + 3) void'(samp.pop_front());
      ev   = (m_n >= S + 3) && (samp[0] != samp[1]);
      xfer = (m_pend != 0) && rdy;
      drop = 0;
      if (ev) m_total = (m_total + 1) % (64'd1 << 32);
      if (ev && !xfer) begin
        if (m_pend == PMAX) drop = 1;
        else                m_pend++;
      end else if (xfer && !ev) begin
        m_pend--;
      end
      if (xfer) m_seq = (m_seq + 1) % SMOD;
      if (drop)     m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    #1;
    if (model_ok) begin
      check("ev_valid", 32'(ev_if.ev_valid), 32'(m_pend != 0));
      check("pend_cnt", 32'(ev_if.pend_cnt), 32'(m_pend));
      check("ev_seq",   32'(ev_if.ev_seq),   32'(m_seq));
      check("overflow", 32'(ev_if.overflow), 32'(m_ovf));
`ifdef TOG_RX_STATS_EN
      check("ev_total", ev_total, 32'(m_total));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(S + 3);
  endtask

  task automatic toggle(input int gap);
    tog_in = ~tog_in;
    tick(gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seq0;
    int gap;
    rst = 1'b1; tog_in = 1'b1; ev_if.ev_ready = 1'b0; ev_if.ovf_clr = 1'b0;
    tick(3);

    // T1: line high through reset, nothing counted
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("t1_valid", 32'(ev_if.ev_valid), 32'd0);
      check("t1_pend",  32'(ev_if.pend_cnt), 32'd0);
    end

    // T2: three queued events then drained in order
    do_reset();
    for (int i = 0; i < 3; i++) toggle(10);
    check("t2_pend",  32'(ev_if.pend_cnt), 32'd3);
    check("t2_seq",   32'(ev_if.ev_seq),   32'd0);
    check("t2_valid", 32'(ev_if.ev_valid), 32'd1);
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_xfer_valid", 32'(ev_if.ev_valid), 32'd1);
      check("t2_xfer_seq",   32'(ev_if.ev_seq),   32'(i));
      tick(1);
    end
    check("t2_drained", 32'(ev_if.ev_valid), 32'd0);
    ev_if.ev_ready = 1'b0;

    // T3: saturate the counter, then clear overflow
    do_reset();
    for (int i = 0; i < 16; i++) toggle(S + 2);
    tick(S + 2);
    check("t3_pend", 32'(ev_if.pend_cnt), 32'd15);
    check("t3_ovf",  32'(ev_if.overflow), 32'd1);
    ev_if.ovf_clr = 1'b1;
    tick(1);
    ev_if.ovf_clr = 1'b0;
    check("t3_ovf_clr",  32'(ev_if.overflow), 32'd0);
    check("t3_pend_clr", 32'(ev_if.pend_cnt), 32'd15);

    // T4: new event lands in the same cycle as a transfer
    do_reset();
    toggle(S + 4);
    check("t4_pend_pre", 32'(ev_if.pend_cnt), 32'd1);
    seq0 = int'(ev_if.ev_seq);
    tog_in = ~tog_in;
    tick(S + 1);
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    check("t4_pend", 32'(ev_if.pend_cnt), 32'd1);
    check("t4_seq",  32'(ev_if.ev_seq),   32'(seq0 + 1));
    tick(2);

    // T5: 260 accepted events wrap ev_seq
    do_reset();
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 260; i++) toggle(S + 2);
    tick(S + 3);
    check("t5_seq",  32'(ev_if.ev_seq),   32'd4);
    check("t5_pend", 32'(ev_if.pend_cnt), 32'd0);
`ifdef TOG_RX_STATS_EN
    check("t5_total", ev_total, 32'd260);
`endif
    ev_if.ev_ready = 1'b0;

    // T6: reset discards pending events; numbering restarts at 0
    do_reset();
    for (int i = 0; i < 5; i++) toggle(S + 2);
    tick(S + 2);
    check("t6_pend_pre", 32'(ev_if.pend_cnt), 32'd5);
    rst = 1'b1;
    tick(1);
    check("t6_pend",  32'(ev_if.pend_cnt), 32'd0);
    check("t6_valid", 32'(ev_if.ev_valid), 32'd0);
    check("t6_seq",   32'(ev_if.ev_seq),   32'd0);
    rst = 1'b0;
    tick(S + 3);
    toggle(S + 2);
    check("t6_first_valid", 32'(ev_if.ev_valid), 32'd1);
    check("t6_first_seq",   32'(ev_if.ev_seq),   32'd0);

    // Random traffic: legal toggle spacing, random ready/clear, rare resets
    do_reset();
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      ev_if.ev_ready = ($urandom_range(0, 2) != 0);
      ev_if.ovf_clr  = ($urandom_range(0, 15) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      gap++;
      if (gap > S && $urandom_range(0, 2) == 0) begin
        tog_in = ~tog_in;
        gap    = 0;
      end
      tick(1);
    end
    rst = 1'b0; ev_if.ev_ready = 1'b0; ev_if.ovf_clr = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
